// File: rtl/rvx_timer_multi_if.sv
// RVX peripheral IO bus: byte-addressed word accesses with one-cycle acknowledges.
interface rvx_timer_multi_if;
  logic [7:0]  rw_address;
  logic [31:0] read_data;
  logic        read_request;
  logic        read_response;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_request;
  logic        write_response;

  modport master (
    output rw_address, read_request, write_data, write_strobe, write_request,
    input  read_data, read_response, write_response
  );

  modport slave (
    input  rw_address, read_request, write_data, write_strobe, write_request,
    output read_data, read_response, write_response
  );
endinterface

// File: rtl/rvx_timer_multi.sv
// Multi-channel RVX system timer: one prescaled up-counter shared by
// NUM_CHANNELS one-shot/periodic compare channels with a merged interrupt.
module rvx_timer_channel #(
  parameter int COUNTER_WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [COUNTER_WIDTH-1:0] counter,
  input  logic                     wr_en,
  input  logic [1:0]               wr_reg,
  input  logic [31:0]              wr_data,
  output logic                     match,
  output logic [COUNTER_WIDTH-1:0] compare,
  output logic [31:0]              period,
  output logic                     ch_enable
);
  // Software touching this channel takes the cycle; the match retries next cycle.
  assign match = ch_enable && (counter >= compare) && !wr_en;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      compare   <= '1;
      period    <= '0;
      ch_enable <= 1'b0;
    end else if (wr_en) begin
      case (wr_reg)
        2'd0:    compare[31:0]               <= wr_data;
        2'd1:    compare[COUNTER_WIDTH-1:32] <= wr_data[COUNTER_WIDTH-33:0];
        2'd2:    period                      <= wr_data;
        default: ch_enable                   <= wr_data[0];
      endcase
    end else if (match) begin
      if (period != '0) compare   <= compare + COUNTER_WIDTH'(period);
      else              ch_enable <= 1'b0;
    end
  end
endmodule

module rvx_timer_multi #(
  parameter int NUM_CHANNELS    = 4,
  parameter int COUNTER_WIDTH   = 64,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  rvx_timer_multi_if.slave        bus,
  output logic                    timer_irq,
  output logic [NUM_CHANNELS-1:0] timer_irq_vector
);
  localparam int NC = NUM_CHANNELS;
  localparam int CW = COUNTER_WIDTH;
  localparam int PW = PRESCALER_WIDTH;

  localparam logic [2:0] A_CTRL     = 3'd0;
  localparam logic [2:0] A_PRESCALE = 3'd1;
  localparam logic [2:0] A_COUNTERL = 3'd2;
  localparam logic [2:0] A_COUNTERH = 3'd3;
  localparam logic [2:0] A_IRQ_EN   = 3'd4;
  localparam logic [2:0] A_IRQ_PEND = 3'd5;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t               wr;
  logic                  glb_sel, ch_sel, wr_glb, cnt_wr;
  logic [2:0]            glb_reg;
  logic [3:0]            ch_slot, ch_idx;
  logic [1:0]            ch_reg;
  logic                  ctrl_en;
  logic [PW-1:0]         prescale, pre_cnt;
  logic [CW-1:0]         counter;
  logic [NC-1:0]         irq_en, pending, match_vec, ch_en, w1c;
  logic [NC-1:0][CW-1:0] ch_cmp;
  logic [NC-1:0][31:0]   ch_per;
  logic [31:0]           rd_mux;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^bus.rw_address[1:0];

  // Only full-word, half-word and low-byte strobes are accepted.
  assign wr.valid = bus.write_request &&
                    (bus.write_strobe == 4'b1111 || bus.write_strobe == 4'b0011 ||
                     bus.write_strobe == 4'b0001);
  assign wr.data  = bus.write_data;

  assign glb_sel = (bus.rw_address[7:5] == 3'b000);
  assign glb_reg = bus.rw_address[4:2];
  assign ch_slot = bus.rw_address[7:4];
  assign ch_idx  = ch_slot - 4'd2;
  assign ch_reg  = bus.rw_address[3:2];
  assign ch_sel  = (ch_slot >= 4'd2) && (int'(ch_idx) < NC);

  assign wr_glb = wr.valid && glb_sel;
  assign cnt_wr = wr_glb && (glb_reg == A_COUNTERL || glb_reg == A_COUNTERH);
  assign w1c    = (wr_glb && glb_reg == A_IRQ_PEND) ? wr.data[NC-1:0] : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ctrl_en  <= 1'b0;
      prescale <= '0;
      pre_cnt  <= '0;
      counter  <= '0;
      irq_en   <= '0;
    end else begin
      if (wr_glb && glb_reg == A_CTRL)     ctrl_en  <= wr.data[0];
      if (wr_glb && glb_reg == A_PRESCALE) prescale <= wr.data[PW-1:0];
      if (wr_glb && glb_reg == A_IRQ_EN)   irq_en   <= wr.data[NC-1:0];
      // A counter write restarts the prescale phase and replaces that cycle's tick.
      if (cnt_wr) begin
        pre_cnt <= '0;
        if (glb_reg == A_COUNTERL) counter[31:0]    <= wr.data;
        else                       counter[CW-1:32] <= wr.data[CW-33:0];
      end else if (!ctrl_en) begin
        pre_cnt <= '0;
      end else if (pre_cnt == prescale) begin
        pre_cnt <= '0;
        counter <= counter + CW'(1);
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end
    end
  end

  for (genvar i = 0; i < NC; i++) begin : g_ch
    rvx_timer_channel #(.COUNTER_WIDTH(CW)) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .counter   (counter),
      .wr_en     (wr.valid && ch_sel && (ch_idx == 4'(i))),
      .wr_reg    (ch_reg),
      .wr_data   (wr.data),
      .match     (match_vec[i]),
      .compare   (ch_cmp[i]),
      .period    (ch_per[i]),
      .ch_enable (ch_en[i])
    );
  end

  // Set beats clear so a coincident match is never lost.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pending          <= '0;
      timer_irq_vector <= '0;
      timer_irq        <= 1'b0;
    end else begin
      pending          <= (pending & ~w1c) | match_vec;
      timer_irq_vector <= pending & irq_en;
      timer_irq        <= |(pending & irq_en);
    end
  end

  always_comb begin
    rd_mux = '0;
    if (glb_sel) begin
      case (glb_reg)
        A_CTRL:     rd_mux = {31'd0, ctrl_en};
        A_PRESCALE: rd_mux = 32'(prescale);
        A_COUNTERL: rd_mux = counter[31:0];
        A_COUNTERH: rd_mux = 32'(counter >> 32);
        A_IRQ_EN:   rd_mux = 32'(irq_en);
        A_IRQ_PEND: rd_mux = 32'(pending);
        default:    rd_mux = '0;
      endcase
    end
    for (int i = 0; i < NC; i++) begin
      if (ch_sel && ch_idx == 4'(i)) begin
        case (ch_reg)
          2'd0:    rd_mux = ch_cmp[i][31:0];
          2'd1:    rd_mux = 32'(ch_cmp[i] >> 32);
          2'd2:    rd_mux = ch_per[i];
          default: rd_mux = {31'd0, ch_en[i]};
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.read_data      <= '0;
      bus.read_response  <= 1'b0;
      bus.write_response <= 1'b0;
    end else begin
      bus.read_response  <= bus.read_request;
      bus.write_response <= bus.write_request;
      if (bus.read_request) bus.read_data <= rd_mux;
    end
  end
endmodule

// File: doc/rvx_timer_multi.md
# rvx_timer_multi

Parametrised multi-channel successor to the single-compare system timer, sitting on the RVX peripheral IO bus. One free-running up-counter with a programmable prescaler feeds NUM_CHANNELS independent compare channels. Each channel runs one-shot or auto-reloading periodic, with its own sticky pending bit and enable. Pending-and-enabled channels are ORed into a single timer interrupt line and also exported as a per-channel vector.

## Interface
- NUM_CHANNELS, 4: number of compare channels, 1..8.
- COUNTER_WIDTH, 64: counter, compare and period width, 33..64. Bits above the width read 0 and ignore writes.
- PRESCALER_WIDTH, 16: width of the PRESCALE register, 1..32.
- clock  in  1  clock.
- reset_n  in  1  reset; synchronous, active-low.
- rw_address  in  8  byte address, word-aligned; bits [1:0] ignored.
- read_data  out  32  registered read data.
- read_request  in  1  read strobe.
- read_response  out  1  read acknowledge.
- write_data  in  32  write data.
- write_strobe  in  4  byte strobes.
- write_request  in  1  write strobe.
- write_response  out  1  write acknowledge.
- timer_irq  out  1  OR of (pending & irq_enable).
- timer_irq_vector  out  NUM_CHANNELS  pending & irq_enable, per channel.

## Operation
- **Register map**
  - 0x00 CTRL: bit0 counter_enable.
  - 0x04 PRESCALE.
  - 0x08 COUNTERL, 0x0C COUNTERH.
  - 0x10 IRQ_ENABLE[N-1:0].
  - 0x14 IRQ_PENDING[N-1:0]: write-1-to-clear.
  - Channel i at 0x20+16*i: +0 CMPL, +4 CMPH, +8 PERIOD, +C CH_CTRL (bit0 ch_enable).
  - Unmapped addresses, and channels with i >= NUM_CHANNELS, read 0 and ignore writes.
- **Write acceptance**
  - A write is valid only when write_request=1 and write_strobe is 4'b1111, 4'b0011 or 4'b0001.
  - A valid write stores the whole write_data word, masked to the field width.
  - Any other strobe is ignored, but write_response is still returned.
- **Reset values**
  - counter 0, prescale count 0, PRESCALE 0, CTRL 0.
  - Every compare all-ones; every PERIOD 0; every ch_enable 0.
  - IRQ_ENABLE 0, IRQ_PENDING 0.
  - read_data 0, read_response 0, write_response 0, timer_irq 0, timer_irq_vector 0.
- **Prescaler**
  - While counter_enable=1, the internal prescale count runs 0..PRESCALE. At PRESCALE it returns to 0 and the counter increments once.
  - PRESCALE=0 means one increment per clock.
  - While counter_enable=0, the prescale count is held at 0.
- **Counter**
  - Counts up and wraps modulo 2^COUNTER_WIDTH.
  - A valid write to COUNTERL or COUNTERH takes priority over an increment that cycle and resets the prescale count to 0.
- **Match**
  - match_i = ch_enable_i && (counter >= compare_i), unsigned, evaluated every cycle.
  - On match_i: pending_i <= 1.
  - If PERIOD_i != 0: compare_i <= compare_i + PERIOD_i, modulo 2^COUNTER_WIDTH. This is periodic mode.
  - If PERIOD_i == 0: ch_enable_i <= 0. This is one-shot mode.
- **Collisions**
  - A valid write to any register of channel i in the same cycle as match_i: the write wins and match_i is suppressed that cycle.
  - A W1C to IRQ_PENDING bit i in the same cycle as a match set of that bit: the set wins.
- **Catch-up**
  - If compare_i lags the counter by more than one period, the channel fires once per cycle until compare_i exceeds the counter.
  - A compare that wraps past 2^COUNTER_WIDTH-1 re-fires every cycle until the counter also wraps. Avoiding this is the responsibility of software.

## Timing
- read_response and write_response equal the request delayed one cycle; there are no wait states.
- read_data updates in the cycle after read_request, with register values sampled at the request edge. It holds when there is no request.
- Match is computed on the current register values. pending updates on the next edge.
- timer_irq and timer_irq_vector are registered from pending & irq_enable, so they rise one cycle after pending sets.
- Minimum latency is 2 cycles from counter reaching compare to timer_irq=1.
- Clearing pending or irq_enable drops timer_irq one cycle later.
- reset_n low mid-operation restores all reset values on that edge and aborts any in-flight response.

## Test plan
- **Reset:** registers and outputs reset → CMPL/CMPH read 0xFFFFFFFF; all other registers and outputs 0.
- **One-shot:** CMP0=10, PRESCALE=0, IRQ_ENABLE=1, ch_enable0=1, enable=1 → pending0 sets once counter ≥ 10, timer_irq one cycle later, ch_enable0 reads 0; W1C 0x1 → timer_irq returns to 0 and stays 0.
- **Periodic prescaled:** PRESCALE=3, CMP1=8, PERIOD1=8 → counter steps every 4 clocks; compare1 reads 16, 24 after successive fires; pending1 sets every 32 clocks.
- **Collision:** write CMPL0 in the exact cycle counter ≥ compare0 → write value stored, no pending set that cycle. W1C coinciding with a match set → pending stays 1.
- **Counter write:** write COUNTERL=0xFFFFFFFF, COUNTERH=0 with enable=1 → counter reads 0x1_00000000 after one increment; the increment is skipped in each write cycle.
- **Strobes and unmapped addresses:** write with strobe 4'b0110 → ignored, write_response still 1; read 0x18 and channel index ≥ NUM_CHANNELS → 0.
